serial_alu_core: RTL and testbench
==================================

// Module: serial_alu_core
// PURPOSE
//   Parametrised successor to the 1-bit ALU tile: computes a WIDTH-bit ALU op
//   serially, BPC bits per cycle, through one combinational slice that is
//   reused each cycle, with a carry register between cycles.
//   Operands enter on a valid/ready handshake; the result leaves on one too.
//   Sits behind the tt_um_* wrapper, which maps the ui_in/uio pins onto it.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 2
//   BPC    1  bits processed per cycle; WIDTH % BPC == 0 (elaboration error if not)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   ena        in   1      tile enable; while low the FSM and all registers hold
//   in_valid   in   1      op/a/b are valid
//   in_ready   out  1      block accepts operands (state IDLE and ena high)
//   op         in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A, 6 NAND, 7 NOR
//   a, b       in   WIDTH  operands, sampled only on the accepting edge
//   out_valid  out  1      result, carry_out and flags are valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  registered result
//   carry_out  out  1      ADD: carry out; SUB: 1 = no borrow; logic ops: 0
//   flags      out  3      [0] zero, [1] negative, [2] signed overflow
// BEHAVIOUR
//   Reset: state IDLE; result, carry_out, flags, out_valid = 0; counter = 0.
//   FSM: IDLE -(in_valid & in_ready)-> RUN -(last chunk)-> DONE -(out_ready)-> IDLE.
//   Accepting edge:
//     - latch a, b and op into shift registers; counter = 0
//     - carry = 1 for SUB, 0 otherwise; SUB computes a + ~b + 1
//   Each RUN edge:
//     - the slice processes the low BPC bits and shifts them in at result MSB
//     - carry register updates; counter increments
//   out_valid rises exactly WIDTH/BPC edges after the accepting edge.
//   Throughput: one op per WIDTH/BPC + 2 cycles.
//   DONE: all outputs held stable until out_ready; in_valid is ignored.
//   result is undefined (not guaranteed 0) during RUN; consumers qualify it with out_valid.
//   ena low in any state: no state change and no handshake completes; in_ready = 0.
//   Async reset mid-RUN/DONE: the op is aborted and not completed; IDLE next edge.
//   Overflow: set for ADD/SUB only (sign of a, b' vs sign of result); 0 for logic ops.
//   Counter width: $clog2(WIDTH/BPC + 1); no wrap inside an op.
// CONFIGURATION
//   ALU_FLAGS_EN defined:
//     - flags computed in the final RUN cycle
//     - registered with the result and held with it
//   ALU_FLAGS_EN undefined:
//     - flags tied to 3'b000
//     - no flag logic synthesised
//     - carry_out unaffected
// STRUCTURE
//   serial_alu_pkg:
//     - alu_op_e (3-bit op enum)
//     - alu_state_e (IDLE/RUN/DONE)
//     - OP_* constants
//   Sub-module alu_slice: combinational BPC-bit slice
//     - inputs: op, a/b chunk, carry_in
//     - outputs: result chunk, carry_out, slice MSB carry (feeds overflow)
// TESTING (WIDTH=8, BPC=1 unless noted)
//   ADD 0xFF+0x01:
//     -> result 0x00, carry_out 1, flags 3'b001
//     -> out_valid high 8 edges after accept
//   SUB 0x05-0x07 -> result 0xFE, carry_out 0, flags 3'b010.
//   ADD 0x7F+0x01 -> result 0x80, flags 3'b110 (ALU_FLAGS_EN); 3'b000 without it.
//   XOR 0xA5^0xFF, out_ready held low 5 cycles:
//     -> result 0x5A held stable, in_ready 0 throughout
//     -> IDLE one edge after out_ready
//   rst_n pulsed low 3 edges into RUN:
//     -> out_valid 0, result 0
//     -> in_ready 1 after release with ena high
//   BPC=4, ADD 0x12+0x34 -> result 0x46, out_valid 2 edges after accept.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types for the serial ALU: op encoding, FSM states and op classification.
package serial_alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_PASS_A = 3'd5,
        OP_NAND   = 3'd6,
        OP_NOR    = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic op_is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational BPC-bit ALU slice, reused every cycle by serial_alu_core.
module alu_slice
    import serial_alu_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [2:0]     i_op,
    input  logic [BPC-1:0] i_a,
    input  logic [BPC-1:0] i_b,
    input  logic           i_carry,
    output logic [BPC-1:0] o_res,
    output logic           o_carry,
    output logic           o_msb_carry
);

    alu_op_e w_op;
    logic    w_c;
    logic    w_bb;

    assign w_op = alu_op_e'(i_op);

    always_comb begin
        o_res       = '0;
        o_msb_carry = 1'b0;
        w_c         = i_carry;
        w_bb        = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            // SUB is a + ~b + 1; the +1 arrives as the initial carry.
            w_bb = (w_op == OP_SUB) ? ~i_b[i] : i_b[i];
            if (i == BPC - 1) o_msb_carry = w_c;
            case (w_op)
                OP_ADD, OP_SUB: o_res[i] = i_a[i] ^ w_bb ^ w_c;
                OP_AND:         o_res[i] = i_a[i] & i_b[i];
                OP_OR:          o_res[i] = i_a[i] | i_b[i];
                OP_XOR:         o_res[i] = i_a[i] ^ i_b[i];
                OP_PASS_A:      o_res[i] = i_a[i];
                OP_NAND:        o_res[i] = ~(i_a[i] & i_b[i]);
                default:        o_res[i] = ~(i_a[i] | i_b[i]);
            endcase
            w_c = (i_a[i] & w_bb) | (w_c & (i_a[i] ^ w_bb));
        end
        o_carry = op_is_arith(w_op) ? w_c : 1'b0;
    end

endmodule

// File: rtl/serial_alu_core.sv
// Serial WIDTH-bit ALU, BPC bits per cycle, with valid/ready on both sides.
// Define ALU_FLAGS_EN to build the zero/negative/overflow flag logic.
module serial_alu_core
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic [2:0]       flags
);

    localparam int NCH   = WIDTH / BPC;
    localparam int CNT_W = $clog2(NCH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

    if ((WIDTH < 2) || (BPC < 1) || (WIDTH % BPC != 0)) begin : g_param_err
        $error("serial_alu_core: WIDTH must be >= 2 and a multiple of BPC");
    end

    alu_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_out_valid;

    logic [BPC-1:0]   w_res_chunk;
    logic             w_slice_carry;
    logic             w_msb_c;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_accept;

    alu_slice #(.BPC(BPC)) u_slice (
        .i_op        (r_op),
        .i_a         (r_a[BPC-1:0]),
        .i_b         (r_b[BPC-1:0]),
        .i_carry     (r_carry),
        .o_res       (w_res_chunk),
        .o_carry     (w_slice_carry),
        .o_msb_carry (w_msb_c)
    );

    // Result fills from the MSB end so the first chunk ends up in the LSBs.
    assign w_res_next = (r_result >> BPC) | (WIDTH'(w_res_chunk) << (WIDTH - BPC));
    assign w_last     = (r_cnt == LAST);
    assign w_accept   = (r_state == IDLE) && in_valid;

    assign in_ready  = (r_state == IDLE) && ena;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry_out;

    always_ff @(posedge clk) begin
        if (ena) begin
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= op;
            end else if (r_state == RUN) begin
                r_a <= r_a >> BPC;
                r_b <= r_b >> BPC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_carry <= (op == OP_SUB);
                    end
                end
                RUN: begin
                    r_result <= w_res_next;
                    r_carry  <= w_slice_carry;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_carry_out <= w_slice_carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic [2:0] r_flags;
    logic       w_ovf;

    // Overflow: carry into the sign bit differs from carry out of it.
    assign w_ovf = op_is_arith(alu_op_e'(r_op)) && (w_msb_c ^ w_slice_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 3'b000;
        end else if (ena && (r_state == RUN) && w_last) begin
            r_flags <= {w_ovf, w_res_next[WIDTH-1], (w_res_next == '0)};
        end
    end

    assign flags = r_flags;
`else
    logic w_unused;
    assign w_unused = w_msb_c;
    assign flags    = 3'b000;
`endif

endmodule

// File: tb/tb_serial_alu_core.sv
// Directed self-checking bench for serial_alu_core (WIDTH=8 with BPC=1 and BPC=4).
module tb_serial_alu_core;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic [2:0] flags;

    logic       in_valid2;
    logic       in_ready2;
    logic       out_valid2;
    logic       out_ready2;
    logic [7:0] result2;
    logic       carry_out2;
    logic [2:0] flags2;

    int n_checks = 0;
    int n_errors = 0;

    serial_alu_core #(.WIDTH(8), .BPC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .flags     (flags)
    );

    serial_alu_core #(.WIDTH(8), .BPC(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .result    (result2),
        .carry_out (carry_out2),
        .flags     (flags2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] fx(input logic [2:0] f);
`ifdef ALU_FLAGS_EN
        return f;
`else
        return 3'b000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge where out_valid is seen.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] xa,
                          input logic [7:0] xb, input int lat, input bit gap);
        int n;
        op       = o;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~xa;
        b        = ~xb;
        op       = o ^ 3'd1;
        n        = 0;
        while (!out_valid && n < 40) begin
            if (gap && n == 2) ena = 1'b0;
            if (gap && n == 5) ena = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, n, lat);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [7:0] r, input logic c, input logic [2:0] f);
        check({tag, ".result"}, {24'd0, result}, {24'd0, r});
        check({tag, ".carry"}, {31'd0, carry_out}, {31'd0, c});
        check({tag, ".flags"}, {29'd0, flags}, {29'd0, fx(f)});
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        ena        = 1'b1;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        op         = 3'd0;
        a          = 8'h00;
        b          = 8'h00;
        repeat (2) @(negedge clk);
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.result", {24'd0, result}, 32'd0);
        check("reset.carry", {31'd0, carry_out}, 32'd0);
        check("reset.flags", {29'd0, flags}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 8, 1'b0);
        check_out("add_ff_01", 8'h00, 1'b1, 3'b001);
        finish_op("add_ff_01");

        run_op("sub_05_07", 3'd1, 8'h05, 8'h07, 8, 1'b0);
        check_out("sub_05_07", 8'hFE, 1'b0, 3'b010);
        finish_op("sub_05_07");

        run_op("sub_07_05", 3'd1, 8'h07, 8'h05, 8, 1'b0);
        check_out("sub_07_05", 8'h02, 1'b1, 3'b000);
        finish_op("sub_07_05");

        run_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 8, 1'b0);
        check_out("add_7f_01", 8'h80, 1'b0, 3'b110);
        finish_op("add_7f_01");

        run_op("sub_80_01", 3'd1, 8'h80, 8'h01, 8, 1'b0);
        check_out("sub_80_01", 8'h7F, 1'b1, 3'b100);
        finish_op("sub_80_01");

        run_op("or_0f_30", 3'd3, 8'h0F, 8'h30, 8, 1'b0);
        check_out("or_0f_30", 8'h3F, 1'b0, 3'b000);
        finish_op("or_0f_30");

        run_op("nand_f0_3c", 3'd6, 8'hF0, 8'h3C, 8, 1'b0);
        check_out("nand_f0_3c", 8'hCF, 1'b0, 3'b010);
        finish_op("nand_f0_3c");

        run_op("nor_f0_3c", 3'd7, 8'hF0, 8'h3C, 8, 1'b0);
        check_out("nor_f0_3c", 8'h03, 1'b0, 3'b000);
        finish_op("nor_f0_3c");

        run_op("pass_00", 3'd5, 8'h00, 8'hFF, 8, 1'b0);
        check_out("pass_00", 8'h00, 1'b0, 3'b001);
        finish_op("pass_00");

        // Enable dropped for three edges mid-run stretches latency by three.
        run_op("and_ena_gap", 3'd2, 8'hF0, 8'h3C, 11, 1'b1);
        check_out("and_ena_gap", 8'h30, 1'b0, 3'b000);
        finish_op("and_ena_gap");

        run_op("xor_hold", 3'd4, 8'hA5, 8'hFF, 8, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("xor_hold.result", {24'd0, result}, 32'h5A);
            check("xor_hold.out_valid", {31'd0, out_valid}, 32'd1);
            check("xor_hold.in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op("xor_hold");

        ena      = 1'b0;
        in_valid = 1'b1;
        op       = 3'd0;
        #1;
        check("ena_low.in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        ena      = 1'b1;
        repeat (10) @(negedge clk);
        check("ena_low.no_accept", {31'd0, out_valid}, 32'd0);
        check("ena_low.in_ready_back", {31'd0, in_ready}, 32'd1);

        op       = 3'd0;
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid.result", {24'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        repeat (12) @(negedge clk);
        check("rst_mid.aborted", {31'd0, out_valid}, 32'd0);

        op        = 3'd0;
        a         = 8'h12;
        b         = 8'h34;
        in_valid2 = 1'b1;
        check("bpc4.in_ready", {31'd0, in_ready2}, 32'd1);
        @(negedge clk);
        in_valid2 = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        n         = 0;
        while (!out_valid2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bpc4.latency", n, 2);
        check("bpc4.result", {24'd0, result2}, 32'h46);
        check("bpc4.carry", {31'd0, carry_out2}, 32'd0);
        check("bpc4.flags", {29'd0, flags2}, {29'd0, fx(3'b000)});
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("bpc4.out_valid_drop", {31'd0, out_valid2}, 32'd0);
        check("bpc4.idle_ready", {31'd0, in_ready2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
